fir_mac_engine: RTL
===================

# fir_mac_engine

Parametrised single-clock FIR filter engine: an input FIFO, a TAPS-deep sample delay line, a writable coefficient bank and a sequential signed multiply-accumulate unit. It generalises the fixed 16-bit, 64-tap, two-clock FIFO/IMEM/CMEM/MAC datapath. It adds configurable width and depth, signed arithmetic, valid/ready handshakes on both sides and per-sample output streaming, and it sits between the sample source and the result consumer in the filter datapath.

## Interface
- DATA_W, 16, sample width (signed)
- COEF_W, 16, coefficient width (signed)
- TAPS, 64, filter length; must be ≥ 2
- FIFO_DEPTH, 8, input FIFO entries; must be a power of 2
- ACC_W, 40, accumulator and result width; must be ≥ DATA_W+COEF_W+clog2(TAPS)
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  sample offered
- in_data  in  DATA_W  signed sample
- in_ready  out  1  FIFO not full; a push occurs on in_valid && in_ready
- coef_we  in  1  coefficient write strobe; honoured only when busy=0
- coef_addr  in  clog2(TAPS)  tap index; addresses ≥ TAPS are ignored
- coef_wdata  in  COEF_W  signed coefficient
- out_valid  out  1  result available
- out_data  out  ACC_W  signed filter result
- out_ready  in  1  consumer accepts; a transfer occurs on out_valid && out_ready
- busy  out  1  FSM not in IDLE
- fifo_count  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy

## Operation
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, fifo_count=0. Delay line, coefficients, accumulator and tap index are all 0.
- FIFO:
  - Synchronous, first-word fall-through internally.
  - A push when full cannot occur, because in_ready=0.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, MAC and OUT.
- IDLE:
  - If fifo_count>0: pop one sample and shift the delay line (x[0]=sample, x[k]=x[k-1], x[TAPS-1] dropped).
  - In the same edge: clear the accumulator, set tap index i=0, go to MAC.
- MAC:
  - Each cycle: acc += x[i]*c[i], with a full-precision signed product sign-extended to ACC_W; then i++.
  - After the product for i=TAPS-1, load out_data=final acc, set out_valid=1, go to OUT.
- OUT:
  - Hold out_valid and out_data stable until out_ready=1.
  - On the transfer edge, clear out_valid and go to IDLE.
  - A queued sample is popped on the next IDLE cycle, not in the same edge.
- Accumulation wraps modulo 2^ACC_W. There is no saturation.
- Coefficient writes:
  - A write with busy=0 updates c[coef_addr] at the edge.
  - coef_we while busy=1 is dropped silently.
  - A coefficient written in the same edge that IDLE leaves for MAC is taken.
- The FIFO keeps accepting input during MAC and OUT until it is full.
- Asserting reset mid-operation aborts immediately and returns everything to reset values. A pending result is lost.

## Timing
- Sample pushed at edge E0 with the FSM in IDLE and the FIFO empty:
  - Popped and shifted at E1.
  - MAC runs edges E2..E(TAPS+1).
  - out_valid=1 after edge E(TAPS+1). At defaults, that is 65 cycles after the push.
- Per-sample period with out_ready tied to 1 is TAPS+2 cycles: 1 IDLE + TAPS MAC + 1 OUT.
- in_ready is derived from registered fifo_count. A pop in the current cycle does not raise in_ready until the next cycle.
- busy rises the edge after pop; it is 1 throughout MAC and OUT and falls on the out transfer edge.

## Test plan
- All coefficients 2, defaults, out_ready=1: push 100 -> out_valid after 65 cycles, out_data=200. Push 1, 2, 3 -> results 202, 206, 212 (the delay line holds the earlier 100).
- Impulse after reset, c[k]=k: push 1 then 4 zeros -> out_data 0, 1, 2, 3, 4 in order.
- Signed math, c[0]=-3 and others 0: push -5 -> 15. Push 16'h8000 -> 98304. With DATA_W=COEF_W=16, TAPS=4, ACC_W=20, all coefficients 16'h8000 and four pushes of 16'h8000 -> the fourth result wraps to 0.
- Backpressure, out_ready=0, push 10 samples back-to-back:
  - The first sample is popped and 8 are queued.
  - in_ready=0 with fifo_count=8 and the 10th sample not accepted.
  - out_data holds stable.
  - Releasing out_ready drains 9 results in order.
- Coefficient write during busy=1 is ignored: c[0] stays at its prior value, checked via the next result. A write during IDLE takes effect for the next sample.
- Reset asserted mid-MAC (cycle 30): out_valid=0, fifo_count=0, busy=0 immediately. A subsequent push of 100 with coefficients rewritten to 2 gives 200, proving the delay line was cleared.

Source files
------------

// File: rtl/fir_mac_engine.sv
// Single-clock FIR engine: input FIFO, TAPS-deep delay line, writable coefficient bank
// and a sequential signed MAC that produces one streamed result per consumed sample.
module fir_mac_engine #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int TAPS       = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_W      = 40
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              in_ready,
  input  logic                              coef_we,
  input  logic [$clog2(TAPS)-1:0]           coef_addr,
  input  logic [COEF_W-1:0]                 coef_wdata,
  output logic                              out_valid,
  output logic [ACC_W-1:0]                  out_data,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int AW = $clog2(TAPS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = DATA_W + COEF_W;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   r_state, w_next;
  logic [DATA_W-1:0]        r_fifo [FIFO_DEPTH];
  logic [FW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic signed [DATA_W-1:0] r_x [TAPS];
  logic signed [COEF_W-1:0] r_c [TAPS];
  logic signed [ACC_W-1:0]  r_acc, r_out_data;
  logic [AW-1:0]            r_idx;
  logic                     r_out_valid;

  logic                     w_push, w_pop, w_last, w_coef_wr;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext, w_acc_next;

  assign in_ready   = (r_count != CW'(FIFO_DEPTH));
  assign w_push     = in_valid && in_ready;
  assign busy       = (r_state != S_IDLE);
  assign w_coef_wr  = coef_we && !busy && (32'(coef_addr) < TAPS);
  assign w_last     = (r_idx == AW'(TAPS-1));
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign fifo_count = r_count;

  // Operands sign-extended to PW so the product is exact; the cast then
  // sign-extends (or wraps, for narrow accumulators) to ACC_W.
  assign w_prod     = PW'(r_x[r_idx]) * PW'(r_c[r_idx]);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_acc_next = r_acc + w_prod_ext;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = S_MAC;
        end
      end
      S_MAC:   if (w_last) w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + FW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);

      if (w_pop) begin
        r_x[0] <= r_fifo[r_rd_ptr];
        for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
        r_acc <= '0;
        r_idx <= '0;
      end

      if (r_state == S_MAC) begin
        r_acc <= w_acc_next;
        r_idx <= w_last ? '0 : r_idx + AW'(1);
        if (w_last) begin
          r_out_data  <= w_acc_next;
          r_out_valid <= 1'b1;
        end
      end

      if (r_state == S_OUT && out_ready) r_out_valid <= 1'b0;

      if (w_coef_wr) r_c[coef_addr] <= coef_wdata;
    end
  end

endmodule
